// File: rtl/io_output_unit.sv
// Memory-mapped I/O block: LED/HEX/LCD store registers, slide-switch synchroniser
// and a free-running cycle counter, all readable through a combinational load mux.
module io_output_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  input  logic        i_wren,
  output logic [31:0] o_rdata,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  localparam logic [29:0] ADDR_LEDR   = 30'h0000_1C00;  // 0x7000
  localparam logic [29:0] ADDR_LEDG   = 30'h0000_1C04;  // 0x7010
  localparam logic [29:0] ADDR_HEX_LO = 30'h0000_1C08;  // 0x7020
  localparam logic [29:0] ADDR_HEX_HI = 30'h0000_1C09;  // 0x7024
  localparam logic [29:0] ADDR_LCD    = 30'h0000_1C0C;  // 0x7030
  localparam logic [29:0] ADDR_SW     = 30'h0000_1E00;  // 0x7800
  localparam logic [29:0] ADDR_CYCLE  = 30'h0000_1E04;  // 0x7810

  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_lcd;
  logic [31:0] r_cycle;
  logic [6:0]  r_hex [8];
  logic [31:0] r_sw_sync [SYNC_STAGES];

  logic [29:0] w_word;
  logic        w_we_ledr;
  logic        w_we_ledg;
  logic        w_we_hex_lo;
  logic        w_we_hex_hi;
  logic        w_we_lcd;
  logic        w_cycle_clr;
  logic [31:0] w_cycle_nxt;
  logic        w_unused_addr;

  function automatic logic [31:0] f_byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

  assign w_word        = i_addr[31:2];
  assign w_unused_addr = ^i_addr[1:0];

  assign w_we_ledr   = i_wren && (w_word == ADDR_LEDR);
  assign w_we_ledg   = i_wren && (w_word == ADDR_LEDG);
  assign w_we_hex_lo = i_wren && (w_word == ADDR_HEX_LO);
  assign w_we_hex_hi = i_wren && (w_word == ADDR_HEX_HI);
  assign w_we_lcd    = i_wren && (w_word == ADDR_LCD);

  // A clearing store outranks the increment of the same edge.
  assign w_cycle_clr = i_wren && (w_word == ADDR_CYCLE) && (|i_bmask);
  assign w_cycle_nxt = w_cycle_clr ? 32'd0 : r_cycle + 32'd1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ledr  <= '0;
      r_ledg  <= '0;
      r_lcd   <= '0;
      r_cycle <= '0;
    end else begin
      if (w_we_ledr) r_ledr <= f_byte_merge(r_ledr, i_wdata, i_bmask);
      if (w_we_ledg) r_ledg <= f_byte_merge(r_ledg, i_wdata, i_bmask);
      if (w_we_lcd)  r_lcd  <= f_byte_merge(r_lcd,  i_wdata, i_bmask);
      r_cycle <= w_cycle_nxt;
    end
  end

  // Each HEX byte keeps only its seven segment bits.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < 8; k++) r_hex[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_we_hex_lo && i_bmask[k]) r_hex[k]   <= i_wdata[8*k +: 7];
        if (w_we_hex_hi && i_bmask[k]) r_hex[k+4] <= i_wdata[8*k +: 7];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sw_sync[s] <= '0;
    end else begin
      r_sw_sync[0] <= i_io_sw;
      for (int s = 1; s < SYNC_STAGES; s++) r_sw_sync[s] <= r_sw_sync[s-1];
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (w_word)
      ADDR_LEDR:   o_rdata = r_ledr;
      ADDR_LEDG:   o_rdata = r_ledg;
      ADDR_HEX_LO: o_rdata = {1'b0, r_hex[3], 1'b0, r_hex[2], 1'b0, r_hex[1], 1'b0, r_hex[0]};
      ADDR_HEX_HI: o_rdata = {1'b0, r_hex[7], 1'b0, r_hex[6], 1'b0, r_hex[5], 1'b0, r_hex[4]};
      ADDR_LCD:    o_rdata = r_lcd;
      ADDR_SW:     o_rdata = r_sw_sync[SYNC_STAGES-1];
      ADDR_CYCLE:  o_rdata = r_cycle;
      default:     o_rdata = 32'd0;
    endcase
  end

  assign o_io_ledr = r_ledr;
  assign o_io_ledg = r_ledg;
  assign o_io_lcd  = r_lcd;
  assign o_io_hex0 = r_hex[0];
  assign o_io_hex1 = r_hex[1];
  assign o_io_hex2 = r_hex[2];
  assign o_io_hex3 = r_hex[3];
  assign o_io_hex4 = r_hex[4];
  assign o_io_hex5 = r_hex[5];
  assign o_io_hex6 = r_hex[6];
  assign o_io_hex7 = r_hex[7];

endmodule

// File: doc/io_output_unit.md
# io_output_unit

Memory-mapped I/O register block between the single-cycle core's load/store path and the board-level pins. It captures CPU stores into the red/green LED, eight seven-segment and LCD output registers, and drives the `o_io_*` outputs that the ISA-test monitor samples. It also synchronises the slide-switch inputs and keeps a free-running cycle counter. Both can be read back by CPU loads.

## Interface
- `SYNC_STAGES`, 2, number of flops in the `i_io_sw` synchroniser (legal range 2..3)
- `i_clk`  in  1  core clock; all state updates on rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_addr`  in  32  load/store byte address from the core
- `i_wdata`  in  32  store data
- `i_bmask`  in  4  byte-enable mask; bit k enables `i_wdata[8k+7:8k]`
- `i_wren`  in  1  store strobe, one cycle per store
- `o_rdata`  out  32  load data, combinational from `i_addr`
- `i_io_sw`  in  32  asynchronous slide-switch inputs
- `o_io_ledr`  out  32  red LED register
- `o_io_ledg`  out  32  green LED register
- `o_io_hex0` … `o_io_hex7`  out  7 each  seven-segment digit registers
- `o_io_lcd`  out  32  LCD control/data register

## Operation
- Address decode compares `i_addr[31:2]` against the word addresses. `i_addr[1:0]` is ignored.
  - 0x7000: LEDR, read/write
  - 0x7010: LEDG, read/write
  - 0x7020: HEX0–HEX3; byte k maps to digit k
  - 0x7024: HEX4–HEX7; byte k maps to digit 4+k
  - 0x7030: LCD, read/write
  - 0x7800: SW, read-only
  - 0x7810: CYCLE, read; any write clears it
- Write: when `i_wren`=1 and the address hits a RW register, each byte whose `i_bmask` bit is 1 is updated at the rising edge. Bytes whose mask bit is 0 keep their value.
- HEX bytes store only bits [6:0]. Bit 7 of each byte is discarded on write and reads as 0.
- Writes to SW are ignored. Writes to unmapped addresses are ignored and have no side effect.
- A write to CYCLE with any nonzero `i_bmask` loads 0. A mask of 0 does nothing.
- Read: `o_rdata` is a pure combinational mux of the current register state, selected by `i_addr`. `i_bmask` does not affect reads. Unmapped addresses return 0x0000_0000.
- SW path: `i_io_sw` passes through a `SYNC_STAGES`-deep flop chain. The SW read returns the last stage.
- CYCLE: a 32-bit counter that increments every clock while out of reset. It wraps from 0xFFFF_FFFF to 0.
- Each `o_io_*` output is driven directly by its register, with no extra output stage.

## Timing
- Reset, asserted asynchronously, sets all of the following to 0 immediately, regardless of clock:
  - LEDR, LEDG, all HEX digits, LCD
  - the synchroniser flops
  - CYCLE
- On reset release, the first rising edge with `i_reset`=1 is the first active edge. CYCLE becomes 1 after that edge.
- Store latency: register and `o_io_*` output show new data one edge after the cycle in which `i_wren` is sampled high. The same-cycle read of the written address returns the old value.
- Back-to-back stores to the same register on consecutive cycles: each takes effect at its own edge; the last one wins.
- Switch latency: a change on `i_io_sw` that is stable before edge N appears on the SW read after edge N+`SYNC_STAGES`-1.
- CYCLE clear versus increment in the same cycle: the clear wins. CYCLE is 0 after that edge and 1 after the next.
- Reset asserted mid-store: the store is lost and outputs stay 0 until reset is released.

## Test plan
- Reset state: assert `i_reset`=0 mid-cycle. All `o_io_*` outputs go to 0 without waiting for a clock edge. A read of 0x7800 returns 0.
- Byte masking:
  - Store 0xDEADBEEF to 0x7000 with mask 0xF.
  - Then store 0x000000AA with mask 0x1.
  - Required: `o_io_ledr`=0xDEADBEAA. The same-cycle read during the second store returns 0xDEADBEEF.
- HEX mapping: store 0xFF80_7F3F to 0x7024 with mask 0xF.
  - Required: `o_io_hex4`=0x3F, `o_io_hex5`=0x7F, `o_io_hex6`=0x00, `o_io_hex7`=0x7F.
  - A read of 0x7024 returns 0x7F00_7F3F.
- Switch synchroniser (`SYNC_STAGES`=2): drive `i_io_sw`=0x0000_00A5 before edge N.
  - A read of 0x7800 returns 0 before edge N+1 and 0xA5 after edge N+1.
  - A write of 0xFFFF_FFFF to 0x7800 leaves the read unchanged.
- CYCLE counter:
  - Force the counter to 0xFFFF_FFFE; after two edges it reads 0.
  - Write to 0x7810 with mask 0x1 at the edge where the count is 5. Required: 0 after that edge, 1 after the next.
  - Write with mask 0x0 at count 5. Required: 6.
- Unmapped access: store 0x1234_5678 to 0x7040 and to 0x0000_2000. All outputs stay unchanged, and reads of both addresses return 0.
